// File: rtl/uart_rx_if.sv
// Receive-side byte port of the UART: received byte with valid/ready handshake plus status.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 busy;
    logic                 frame_error;
    logic                 overrun;

    modport master (
        output data, valid, busy, frame_error, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, busy, frame_error, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: start-bit mid-point alignment on rxClk-derived ticks,
// byte presented on a valid/ready port with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rxClk,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    logic rx_meta;
    logic rx_s;
    logic rxclk_d;
    logic tick_c;

    // Two-flop synchronizer on the asynchronous line plus rxClk edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rxclk_d <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rxclk_d <= rxClk;
        end
    end

    assign tick_c = rxClk & ~rxclk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            bus.data        <= '0;
            bus.valid       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            bus.frame_error <= 1'b0;
            bus.overrun     <= 1'b0;
            if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end

            if (tick_c) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            count    <= '0;
                            bus.busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (count == CNT_HALF) begin
                            count <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    DATA: begin
                        if (count == CNT_LAST) begin
                            // LSB arrives first, so shift right from the MSB end.
                            shift   <= {rx_s, shift[DATA_BITS-1:1]};
                            count   <= '0;
                            bit_idx <= bit_idx + IW'(1);
                            if (bit_idx == IDX_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    STOP: begin
                        if (count == CNT_LAST) begin
                            state    <= IDLE;
                            count    <= '0;
                            bus.busy <= 1'b0;
                            if (rx_s) begin
                                // New byte wins; a consume on this same clk is not an overrun.
                                bus.data  <= shift;
                                bus.valid <= 1'b1;
                                if (bus.valid && !bus.ready) begin
                                    bus.overrun <= 1'b1;
                                end
                            end else begin
                                bus.frame_error <= 1'b1;
                            end
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 (configurable data width) UART receiver for the serial-input side of the UART.
- Runs entirely on the system clock. Uses the rxClk output of the baud rate generator (toggles at 2x oversample rate) as a sampling-tick source, not as a clock.
- Recovers bytes from the serial line by start-bit mid-point alignment. Presents each byte on a valid/ready output port and flags framing errors and overruns.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; 5..9 supported.
- OVERSAMPLE, 16, rxClk ticks per bit; must equal the generator's RX_OVERSAMPLE_RATE; even, >=4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rxClk  input  1  oversample clock level from generator; synchronous to clk, so no synchronizer is needed.
- rx  input  1  serial line, idle high; asynchronous.
- data  output  DATA_BITS  last received byte.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid && ready.
- busy  output  1  frame in progress (START/DATA/STOP).
- frame_error  output  1  one-clk pulse: stop bit sampled 0.
- overrun  output  1  one-clk pulse: byte completed while the previous byte was unconsumed.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, count=0, bit_idx=0, shift=0.
  - data=0, valid=0, busy=0, frame_error=0, overrun=0.
  - rx synchronizer flops=1, rxClk_d=0.
- rx passes through a 2-flop synchronizer (rx_s). The FSM uses only rx_s.
- tick = rxClk && !rxClk_d, with rxClk_d registered each clk. Exactly one tick per rxClk rising edge. All FSM advances occur only on clk cycles with tick=1.
- count width clog2(OVERSAMPLE); bit_idx width clog2(DATA_BITS+1).
- IDLE: on tick with rx_s=0, go to START, count=0. busy=0 in IDLE.
- START: on tick:
  - if count==OVERSAMPLE/2-1, sample rx_s.
    - 0: go to DATA, count=0, bit_idx=0.
    - 1: glitch; go to IDLE with no output.
  - else count++.
  - Net effect: mid start bit is sampled OVERSAMPLE/2 ticks after detection.
- DATA: on tick:
  - if count==OVERSAMPLE-1, shift rx_s in at the MSB (shift right), so the first bit received lands at bit 0 after DATA_BITS shifts. Then count=0, bit_idx++. When bit_idx reaches DATA_BITS, go to STOP.
  - else count++.
- STOP: on tick with count==OVERSAMPLE-1, sample rx_s and go to IDLE.
  - 1: data<=shift, valid<=1 on the next clk edge.
  - 0: frame_error pulses for 1 clk; data and valid are unchanged.
- Sample points relative to detection tick T0: start T0+8, data bit k (0-based) T0+24+16k, stop T0+152 (OVERSAMPLE=16, 8 bits).
- After the stop sample, IDLE is entered immediately, so back-to-back frames are received with no gap.
- valid/ready:
  - valid is cleared on a clk with valid && ready.
  - If a byte completes on the same clk that valid && ready: the new byte is loaded, valid stays 1, no overrun.
  - If a byte completes while valid=1 and ready=0: data is overwritten with the new byte, valid stays 1, and overrun pulses for 1 clk.
- A framing error never touches valid/data and never raises overrun.
- Level of rx between sample points is ignored. There is no majority voting.

Test Plan:
1. Assert reset mid-simulation with rx=1 -> data=0x00, valid=0, busy=0, frame_error=0, overrun=0 immediately (before the next clk edge).
2. Bench toggles rxClk every 2 clk (tick every 4 clk, bit = 64 clk). Send 0xA5, stop=1, ready=0 -> valid=1 with data=0xA5 held indefinitely. Raise ready for 1 clk -> valid=0 the next cycle; busy high from detection to the stop sample.
3. Pull rx low for 4 ticks then high -> busy rises then falls after 8 ticks; valid stays 0 and frame_error stays 0. A following frame 0x3C is received correctly.
4. Send 0x5A with stop bit 0 -> frame_error single-clk pulse at the stop sample, valid=0, data still shows the prior value. The next good frame 0x81 is received correctly.
5. Send 0x3C then 0xC3 back-to-back with ready=0 -> overrun single pulse when 0xC3 completes, data=0xC3, valid=1. Repeat with ready=1 exactly on the completion cycle -> no overrun, data=0xC3, valid=1.
6. Assert reset during data bit 4 of 0xFF -> all outputs 0. Deassert, then send 0x42 -> data=0x42, valid=1, no frame_error.
